// File: rtl/dii_package.sv
// dii_package: shared DII flit type, packet-type codes and flags-flit layout
// for the debug-interconnect blocks.
package dii_package;

  // One flit on a DII stream: handshake valid, end-of-packet marker, payload.
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam logic [1:0] DII_TYPE_EVENT        = 2'b10;
  localparam logic [3:0] DII_TYPE_SUB_OVERFLOW = 4'hF;

  // Flags flit layout: type in [15:14], sub-type in [13:10], rest zero.
  localparam int DII_FLAGS_TYPE_LSB = 14;
  localparam int DII_FLAGS_SUB_LSB  = 10;

  localparam logic [15:0] DII_DROP_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] dii_event_flags(input logic [3:0] type_sub);
    dii_event_flags = '0;
    dii_event_flags[DII_FLAGS_TYPE_LSB +: 2] = DII_TYPE_EVENT;
    dii_event_flags[DII_FLAGS_SUB_LSB +: 4]  = type_sub;
  endfunction

endpackage

// File: rtl/dii_overflow_counter.sv
// dii_overflow_counter: saturating count of dropped events. The owner reads
// cnt as its snapshot and pulses clear in the same cycle; a drop arriving in
// that cycle becomes the first count of the next interval.
module dii_overflow_counter
  import dii_package::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clear,
  output logic [15:0] cnt
);

  // Saturating increment with snapshot-clear taking priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= {15'b0, inc};
    end else if (inc && (cnt != DII_DROP_CNT_MAX)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/dii_packetizer.sv
// dii_packetizer: turns one debug event into a DII packet
// (dest, src, flags, payload words) on a valid/ready flit stream.
// Optional feature macro OSD_PKTZ_OVERFLOW_EN: never stall events, count the
// ones that arrive while busy and report them in a trailing overflow packet.
module dii_packetizer
  import dii_package::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int MAX_PAYLOAD = 8,
  localparam int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             id,
  input  logic [WIDTH-1:0]             event_dest,
  input  logic [3:0]                   event_type_sub,
  input  logic [LEN_W-1:0]             event_len,
  input  logic [MAX_PAYLOAD*WIDTH-1:0] event_data,
  input  logic                         event_valid,
  output logic                         event_ready,
  output dii_flit                      flit_out,
  input  logic                         flit_out_ready
);

  typedef enum logic [2:0] {S_IDLE, S_DEST, S_SRC, S_FLAGS, S_PAYLOAD} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         dest_q;
  logic [3:0]               sub_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         idx_q;
  logic [MAX_PAYLOAD*WIDTH-1:0] data_q;
  dii_flit                  flit;
  logic                     accept;
  logic                     pop;
  logic                     final_pop;
  logic                     start_ovf;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    clamp_len = (len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : len;
  endfunction

  function automatic logic [WIDTH-1:0] word_at(input logic [MAX_PAYLOAD*WIDTH-1:0] d,
                                               input logic [LEN_W-1:0] i);
    word_at = '0;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (i == LEN_W'(k)) word_at = d[k*WIDTH +: WIDTH];
    end
  endfunction

  assign accept    = event_valid && (state_q == S_IDLE);
  assign pop       = flit.valid && flit_out_ready;
  assign final_pop = pop && flit.last;

`ifdef OSD_PKTZ_OVERFLOW_EN
  logic [15:0] drop_cnt;

  dii_overflow_counter u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (event_valid && (state_q != S_IDLE)),
    .clear (start_ovf),
    .cnt   (drop_cnt)
  );

  assign start_ovf   = final_pop && (drop_cnt != 16'd0);
  assign event_ready = 1'b1;
`else
  assign start_ovf   = 1'b0;
  assign event_ready = (state_q == S_IDLE);
`endif

  assign flit_out = flit;

  // Next-state and flit output, decoded from registered state only
  always_comb begin
    state_d = state_q;
    flit    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_DEST;
      end
      S_DEST: begin
        flit.valid = 1'b1;
        flit.data  = dest_q;
        if (pop) state_d = S_SRC;
      end
      S_SRC: begin
        flit.valid = 1'b1;
        flit.data  = id;
        if (pop) state_d = S_FLAGS;
      end
      S_FLAGS: begin
        flit.valid = 1'b1;
        flit.data  = dii_event_flags(sub_q);
        flit.last  = (len_q == '0);
        if (pop) state_d = (len_q == '0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        flit.valid = 1'b1;
        flit.data  = word_at(data_q, idx_q);
        flit.last  = (idx_q == len_q - LEN_W'(1));
        if (pop && flit.last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_ovf) state_d = S_DEST;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Event capture, payload word index and overflow-packet load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q <= '0;
      sub_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      dest_q <= event_dest;
      sub_q  <= event_type_sub;
      len_q  <= clamp_len(event_len);
      idx_q  <= '0;
      data_q <= event_data;
    end else if (start_ovf) begin
      // dest_q keeps the last accepted destination for the overflow report
      sub_q  <= DII_TYPE_SUB_OVERFLOW;
      len_q  <= LEN_W'(1);
      idx_q  <= '0;
      data_q <= '0;
`ifdef OSD_PKTZ_OVERFLOW_EN
      data_q[15:0] <= drop_cnt;
`endif
    end else if (pop && (state_q == S_PAYLOAD) && !flit.last) begin
      idx_q <= idx_q + LEN_W'(1);
    end
  end

endmodule
